// File: rtl/snake_input_ctrl.sv
// Snake input front end: synchronised/debounced buttons, IDLE/RUN/END game FSM,
// and a move tick whose period shrinks with tail length.
`ifndef LEFT_DIR
`define LEFT_DIR 2'd0
`endif
`ifndef TOP_DIR
`define TOP_DIR 2'd1
`endif
`ifndef RIGHT_DIR
`define RIGHT_DIR 2'd2
`endif
`ifndef DOWN_DIR
`define DOWN_DIR 2'd3
`endif
`ifndef TAIL_SIZE
`define TAIL_SIZE [7:0]
`endif

module snake_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BASE_PERIOD     = 6250000,
  parameter int STEP            = 125000,
  parameter int MIN_PERIOD      = 1562500,
  parameter int RST_CYCLES      = 4
) (
  input  logic            vga_clk,
  input  logic            reset,
  input  logic [3:0]      btn_n,
  input  logic            game_over,
  input  logic            game_won,
  input  logic `TAIL_SIZE tail_count,
  output logic [0:1]      direction,
  output logic            update_tick,
  output logic            game_reset,
  output logic            running
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int MAX_P = (BASE_PERIOD > MIN_PERIOD) ? BASE_PERIOD : MIN_PERIOD;
  localparam int CNT_W = $clog2(MAX_P + 1);
  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
  localparam logic [63:0] BASE_W = 64'(BASE_PERIOD);
  localparam logic [63:0] MIN_W  = 64'(MIN_PERIOD);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_END} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [3:0]         w_press;
  logic               w_evt;
  logic [1:0]         w_evt_dir;
  logic [1:0]         r_dir;
  logic [1:0]         r_pending;
  logic [1:0]         w_ref;
  logic [1:0]         w_ref_opp;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_period;
  logic [CNT_W-1:0]   w_period_calc;
  logic [63:0]        w_reduction;
  logic [63:0]        w_period_full;
  logic               r_commit_q;
  logic               r_tick;
  logic               r_rst_active;
  logic [RST_W-1:0]   r_rst_cnt;
  logic               w_stop;
  logic               w_start;
  logic               w_commit;
  logic               w_rst_begin;
  logic               w_rst_done;

  // Per-button synchroniser, debouncer and rising-edge (press) detector.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic            r_sync1;
      logic            r_sync2;
      logic            r_level;
      logic            r_prev;
      logic [DB_W-1:0] r_db_cnt;
      logic            w_sample;

      assign w_sample = ~r_sync2;

      always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
          r_sync1  <= 1'b1;
          r_sync2  <= 1'b1;
          r_level  <= 1'b0;
          r_prev   <= 1'b0;
          r_db_cnt <= '0;
        end else begin
          r_sync1 <= btn_n[gi];
          r_sync2 <= r_sync1;
          r_prev  <= r_level;
          if (w_sample == r_level) begin
            r_db_cnt <= '0;
          end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_level  <= w_sample;
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end
      end

      assign w_press[gi] = r_level & ~r_prev;
    end
  endgenerate

  assign w_evt = |w_press;

  always_comb begin
    w_evt_dir = `DOWN_DIR;
    if (w_press[0])      w_evt_dir = `LEFT_DIR;
    else if (w_press[1]) w_evt_dir = `TOP_DIR;
    else if (w_press[2]) w_evt_dir = `RIGHT_DIR;
  end

  // Period is computed wide so a large tail never wraps below the floor.
  assign w_reduction = 64'(STEP) * 64'(tail_count);

  always_comb begin
    if ((w_reduction >= BASE_W) || ((BASE_W - w_reduction) < MIN_W))
      w_period_full = MIN_W;
    else
      w_period_full = BASE_W - w_reduction;
  end

  assign w_period_calc = CNT_W'(w_period_full);
  assign w_stop        = game_over | game_won;

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_commit     = 1'b0;
    w_rst_begin  = 1'b0;
    w_rst_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_evt) begin
          w_state_next = S_RUN;
          w_start      = 1'b1;
        end
      end
      S_RUN: begin
        if (w_stop)
          w_state_next = S_END;
        else if (r_cnt == r_period - 1'b1)
          w_commit = 1'b1;
      end
      S_END: begin
        if (r_rst_active) begin
          if (r_rst_cnt == RST_W'(RST_CYCLES - 1)) begin
            w_rst_done   = 1'b1;
            w_state_next = S_IDLE;
          end
        end else if (w_evt) begin
          w_rst_begin = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // During the commit cycle the reversal check uses the value being committed,
  // so two quick turns inside one tick cannot fold the snake back on itself.
  assign w_ref     = w_commit ? r_pending : r_dir;
  assign w_ref_opp = w_ref ^ 2'b10;

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      r_dir     <= `RIGHT_DIR;
      r_pending <= `RIGHT_DIR;
    end else if (w_start) begin
      r_dir     <= w_evt_dir;
      r_pending <= w_evt_dir;
    end else if (w_rst_begin) begin
      r_dir     <= `RIGHT_DIR;
      r_pending <= `RIGHT_DIR;
    end else if ((r_state == S_RUN) && !w_stop) begin
      if (w_commit)
        r_dir <= r_pending;
      if (w_evt && (w_evt_dir != w_ref_opp))
        r_pending <= w_evt_dir;
    end
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_period <= '0;
    end else if (w_start || w_commit) begin
      r_cnt    <= '0;
      r_period <= w_period_calc;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Tick lags the direction update by one cycle so direction is settled
  // for a full cycle before the game logic sees the tick edge.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      r_commit_q <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_commit_q <= w_commit;
      r_tick     <= r_commit_q & (r_state == S_RUN) & ~w_stop;
    end
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      r_rst_active <= 1'b0;
      r_rst_cnt    <= '0;
    end else if (w_rst_begin) begin
      r_rst_active <= 1'b1;
      r_rst_cnt    <= '0;
    end else if (w_rst_done) begin
      r_rst_active <= 1'b0;
      r_rst_cnt    <= '0;
    end else if (r_rst_active) begin
      r_rst_cnt <= r_rst_cnt + 1'b1;
    end
  end

  assign direction   = r_dir;
  assign update_tick = r_tick;
  assign game_reset  = r_rst_active;
  assign running     = (r_state == S_RUN);

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Directed bench for snake_input_ctrl: expected ticks (direction, spacing) are
// queued when stimulus is applied and compared when the DUT emits update_tick.
module tb_snake_input_ctrl;
  localparam logic [1:0] LEFT  = 2'd0;
  localparam logic [1:0] TOP   = 2'd1;
  localparam logic [1:0] RIGHT = 2'd2;
  localparam logic [1:0] DOWN  = 2'd3;

  logic       vga_clk = 1'b0;
  logic       reset;
  logic [3:0] btn_n;
  logic       game_over;
  logic       game_won;
  logic [7:0] tail_count;
  logic [0:1] direction;
  logic       update_tick;
  logic       game_reset;
  logic       running;

  always #5 vga_clk = ~vga_clk;

  snake_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .BASE_PERIOD(100),
    .STEP(10),
    .MIN_PERIOD(20),
    .RST_CYCLES(4)
  ) dut (
    .vga_clk(vga_clk),
    .reset(reset),
    .btn_n(btn_n),
    .game_over(game_over),
    .game_won(game_won),
    .tail_count(tail_count),
    .direction(direction),
    .update_tick(update_tick),
    .game_reset(game_reset),
    .running(running)
  );

  typedef struct {
    logic [1:0] dir;
    int         gap;
  } tick_t;

  tick_t exp_q[$];
  tick_t obs_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_ev_cyc = 0;
  int    gr_cycles = 0;
  int    t_ref = 0;
  logic  run_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; samples 1 time unit after the edge and logs any tick seen.
  task automatic step();
    tick_t t;
    @(posedge vga_clk);
    #1;
    cyc++;
    if (running === 1'b1 && run_prev !== 1'b1) last_ev_cyc = cyc;
    run_prev = running;
    if (game_reset === 1'b1) gr_cycles++;
    if (update_tick === 1'b1) begin
      t.dir = direction;
      t.gap = cyc - last_ev_cyc;
      obs_q.push_back(t);
      last_ev_cyc = cyc;
    end
  endtask

  task automatic press(input int b, input int hold);
    btn_n[b] = 1'b0;
    repeat (hold) step();
    btn_n[b] = 1'b1;
    repeat (8) step();
  endtask

  task automatic expect_tick(input logic [1:0] d, input int gap);
    tick_t t;
    t.dir = d;
    t.gap = gap;
    exp_q.push_back(t);
  endtask

  task automatic wait_tick(input string tag);
    tick_t o;
    tick_t e;
    int    n = 0;
    while (obs_q.size() == 0 && n < 300) begin
      step();
      n++;
    end
    check({tag, "_present"}, 32'(obs_q.size() > 0), 32'd1);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_dir"}, 32'(o.dir), 32'(e.dir));
      check({tag, "_gap"}, 32'(o.gap), 32'(e.gap));
      $display("tick %s: dir=%0d gap=%0d", tag, o.dir, o.gap);
    end
  endtask

  initial begin
    reset      = 1'b0;
    btn_n      = 4'hF;
    game_over  = 1'b0;
    game_won   = 1'b0;
    tail_count = 8'd0;
    repeat (3) step();
    check("rst_dir", 32'(direction), 32'(RIGHT));
    check("rst_tick", 32'(update_tick), 32'd0);
    check("rst_game_reset", 32'(game_reset), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    reset = 1'b1;
    repeat (2) step();

    // Short glitch on top must not register.
    btn_n[1] = 1'b0;
    repeat (3) step();
    btn_n[1] = 1'b1;
    repeat (20) step();
    check("glitch_running", 32'(running), 32'd0);
    check("glitch_dir", 32'(direction), 32'(RIGHT));
    check("glitch_no_tick", 32'(obs_q.size()), 32'd0);

    // IDLE -> RUN on down press; first tick 101 cycles after entry.
    expect_tick(DOWN, 101);
    expect_tick(DOWN, 100);
    press(3, 10);
    check("start_running", 32'(running), 32'd1);
    check("start_dir", 32'(direction), 32'(DOWN));
    wait_tick("first");
    wait_tick("second");

    expect_tick(RIGHT, 100);
    press(2, 10);
    wait_tick("turn_right");

    // Reversal against current direction is dropped.
    expect_tick(RIGHT, 100);
    press(0, 10);
    wait_tick("left_rejected");

    // Top mid-period, then left landing exactly in the commit cycle.
    t_ref = cyc;
    expect_tick(TOP, 100);
    expect_tick(LEFT, 100);
    press(1, 10);
    while (cyc - t_ref < 92) step();
    press(0, 10);
    wait_tick("commit_top");
    wait_tick("commit_left");

    // Speed-up: period sampled at the following reload.
    tail_count = 8'd5;
    expect_tick(LEFT, 100);
    expect_tick(LEFT, 50);
    wait_tick("tail5_a");
    wait_tick("tail5_b");
    tail_count = 8'd20;
    expect_tick(LEFT, 50);
    expect_tick(LEFT, 20);
    expect_tick(LEFT, 20);
    wait_tick("tail20_a");
    wait_tick("tail20_b");
    wait_tick("tail20_c");

    // Game over: ticks stop, direction frozen, press triggers the reset pulse.
    game_over = 1'b1;
    repeat (60) step();
    check("over_no_tick", 32'(obs_q.size()), 32'd0);
    check("over_running", 32'(running), 32'd0);
    check("over_dir_frozen", 32'(direction), 32'(LEFT));
    gr_cycles = 0;
    press(2, 10);
    game_over = 1'b0;
    check("game_reset_len", 32'(gr_cycles), 32'd4);
    check("after_end_dir", 32'(direction), 32'(RIGHT));
    check("after_end_idle", 32'(running), 32'd0);
    $display("game_reset pulse: %0d cycles", gr_cycles);

    // Async reset mid-period with a pending turn queued.
    tail_count = 8'd0;
    press(0, 10);
    check("restart_running", 32'(running), 32'd1);
    check("restart_dir", 32'(direction), 32'(LEFT));
    press(1, 10);
    #3;
    reset = 1'b0;
    #1;
    check("async_dir", 32'(direction), 32'(RIGHT));
    check("async_tick", 32'(update_tick), 32'd0);
    check("async_running", 32'(running), 32'd0);
    check("async_game_reset", 32'(game_reset), 32'd0);
    repeat (3) step();
    reset = 1'b1;
    repeat (250) step();
    check("post_rst_no_tick", 32'(obs_q.size()), 32'd0);
    check("post_rst_running", 32'(running), 32'd0);
    check("post_rst_dir", 32'(direction), 32'(RIGHT));
    check("exp_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
